afe_tot_array: RTL and testbench
================================

AFE_TOT_ARRAY -- requirements
Module: afe_tot_array

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of comparator channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning TOT counter width per channel (4..12).
REQ-003 The block SHALL have parameter GPIO_W, default 8, meaning GPIO register width.
REQ-004 The block SHALL have port CLK  input  1  meaning the single system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port RST_B  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port INJ_IN  input  1  meaning shared arm/injection strobe; low clears and arms all channels.
REQ-007 The block SHALL have port COMP  input  N_CH  meaning asynchronous discriminator outputs, one bit per channel.
REQ-008 The block SHALL have port CS_B  input  1  meaning SPI chip select, active-low.
REQ-009 The block SHALL have port SCLK  input  1  meaning SPI clock, mode 0, at most CLK/8.
REQ-010 The block SHALL have port MOSI  input  1  meaning SPI data in, MSB first.
REQ-011 The block SHALL have port MISO  output  1  meaning SPI data out, MSB first.
REQ-012 The block SHALL have port HIT  output  N_CH  meaning registered per-channel hit flags.
REQ-013 The block SHALL have port INJ_OUT  output  1  meaning combinational copy of INJ_IN.
REQ-014 The block SHALL have port GPIO  output  GPIO_W  meaning the registered GPIO word.
REQ-015 The block SHALL have port LED  output  1  meaning high while any HIT bit is set.

Function
REQ-016 The block SHALL synchronise INJ_IN, each COMP bit, CS_B, SCLK and MOSI through two CLK flip-flops before use.
REQ-017 Each channel SHALL run an FSM with states IDLE, WAIT, COUNT and DONE.
REQ-018 IDLE -> WAIT SHALL occur when synced INJ_IN=1 and ch_en[i]=1; a disabled channel SHALL stay in IDLE with HIT[i]=0.
REQ-019 WAIT -> COUNT SHALL occur on synced COMP[i]=1; HIT[i] SHALL set in the same cycle, giving 3 CLK latency from the COMP pin.
REQ-020 In COUNT, cnt[i] SHALL increment by 1 per CLK while synced COMP[i]=1 and SHALL saturate at 2^CNT_W-1, setting ovf[i].
REQ-021 COUNT -> DONE SHALL occur on synced COMP[i]=0; tot_lat[i]<=cnt[i], ovf_lat[i]<=ovf[i] and valid[i]<=1 in that cycle.
REQ-022 In DONE, further COMP[i] pulses SHALL be ignored.
REQ-023 Synced INJ_IN=0 SHALL force every channel from any state to IDLE, clearing cnt, ovf and HIT; tot_lat, ovf_lat and valid SHALL be retained.
REQ-024 SPI bit timing: synced SCLK rise SHALL sample MOSI into rx_sr; synced SCLK fall SHALL shift tx_sr left, filling with 0.
REQ-025 On synced CS_B fall, tx_sr SHALL load the snapshot {valid,ovf_lat,tot_lat} for channel N_CH-1 down to 0, width N_CH*(CNT_W+2).
REQ-026 If a channel's DONE entry coincides with the snapshot cycle, the snapshot SHALL hold the pre-update value.
REQ-027 MISO SHALL equal tx_sr MSB while CS_B=0 and 0 while CS_B=1; it SHALL be 0 after all snapshot bits are shifted out.
REQ-028 On synced CS_B rise, if the bit count is at least N_CH+GPIO_W, the last N_CH+GPIO_W received bits SHALL be written as {ch_en,gpio_reg}; shorter frames SHALL be discarded.
REQ-029 On synced CS_B rise, valid[] SHALL clear (read-clears), unless a DONE entry occurs in that same cycle, in which case valid SHALL be set.
REQ-030 The bit counter SHALL saturate and not wrap, so frames longer than 2^8-1 bits are still accepted.

Reset
REQ-031 RST_B=0 SHALL immediately set all FSMs to IDLE and clear cnt, ovf, tot_lat, ovf_lat, valid, HIT, rx_sr, tx_sr, the bit counter and gpio_reg.
REQ-032 RST_B=0 SHALL set ch_en to all ones.
REQ-033 During reset, MISO SHALL be 0, GPIO SHALL be 0 and LED SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame, with no register write after release.

Verification (N_CH=4, CNT_W=8, GPIO_W=8)
REQ-035 INJ_IN high, COMP[0] high for 20 CLK -> HIT[0] rises 3 CLK after COMP; readout ch0 = valid 1, ovf 0, tot 20.
REQ-036 COMP[2] high for 300 CLK -> ch2 tot 255, ovf 1; a second COMP[2] pulse in DONE leaves the value unchanged.
REQ-037 A 12-bit frame with MOSI=0x0_A5 -> ch_en=0x0, GPIO=0xA5; a subsequent COMP pulse gives HIT=0 with no valid; a 10-bit frame leaves GPIO unchanged.
REQ-038 A 40-bit read after a hit -> the first 40 MISO bits match the snapshot and bits beyond are 0; a second read shows valid=0.
REQ-039 INJ_IN low for 2 CLK while in COUNT -> HIT clears and the FSM returns to IDLE, with the previous tot_lat retained.
REQ-040 RST_B pulsed low mid-frame and mid-COUNT -> all outputs 0, ch_en=0xF, and the next frame's snapshot is all 0.

Source files
------------

// File: rtl/afe_tot_array.sv
// afe_tot_array: per-channel time-over-threshold counters with hit flags,
// snapshot readout and a small configuration register, all behind a mode-0 SPI.
module afe_tot_array #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RST_B,
    input  logic              INJ_IN,
    input  logic [N_CH-1:0]   COMP,
    input  logic              CS_B,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [N_CH-1:0]   HIT,
    output logic              INJ_OUT,
    output logic [GPIO_W-1:0] GPIO,
    output logic              LED
);
    localparam int CFG_W  = N_CH + GPIO_W;
    localparam int SNAP_W = N_CH * (CNT_W + 2);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, COUNT, DONE} state_t;

    logic [1:0]        inj_sy;
    logic [N_CH-1:0]   comp_m, comp_s;
    logic [2:0]        cs_sy, sclk_sy;
    logic [1:0]        mosi_sy;

    state_t            st [N_CH];
    state_t            st_nx [N_CH];
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [CNT_W-1:0]  cnt_nx [N_CH];
    logic [CNT_W-1:0]  tot_lat [N_CH];
    logic [N_CH-1:0]   ovf, ovf_nx, hit_nx, done_ent, ovf_lat, valid, ch_en;

    logic [SNAP_W-1:0] tx_sr, snap;
    logic [CFG_W-1:0]  rx_sr;
    logic [7:0]        bcnt;
    logic [GPIO_W-1:0] gpio_reg;

    logic inj_s, cs_s, cs_d, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            inj_sy  <= '0;
            comp_m  <= '0;
            comp_s  <= '0;
            cs_sy   <= '1;
            sclk_sy <= '0;
            mosi_sy <= '0;
        end else begin
            inj_sy  <= {inj_sy[0], INJ_IN};
            comp_m  <= COMP;
            comp_s  <= comp_m;
            cs_sy   <= {cs_sy[1:0], CS_B};
            sclk_sy <= {sclk_sy[1:0], SCLK};
            mosi_sy <= {mosi_sy[0], MOSI};
        end
    end

    assign inj_s     = inj_sy[1];
    assign cs_s      = cs_sy[1];
    assign cs_d      = cs_sy[2];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_sy[2] & sclk_sy[1];
    assign sclk_fall = sclk_sy[2] & ~sclk_sy[1];
    assign mosi_s    = mosi_sy[1];

    // The WAIT->COUNT cycle already counts as one cycle of COMP high.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            st_nx[i]    = st[i];
            cnt_nx[i]   = cnt[i];
            ovf_nx[i]   = ovf[i];
            hit_nx[i]   = HIT[i];
            done_ent[i] = 1'b0;
            if (!inj_s) begin
                st_nx[i]  = IDLE;
                cnt_nx[i] = '0;
                ovf_nx[i] = 1'b0;
                hit_nx[i] = 1'b0;
            end else begin
                case (st[i])
                    IDLE:  st_nx[i] = ch_en[i] ? WAIT : IDLE;
                    WAIT:  if (comp_s[i]) begin
                               st_nx[i]  = COUNT;
                               hit_nx[i] = 1'b1;
                               cnt_nx[i] = CNT_W'(1);
                           end
                    COUNT: if (comp_s[i]) begin
                               cnt_nx[i] = (cnt[i] == CMAX) ? cnt[i] : cnt[i] + 1'b1;
                               ovf_nx[i] = ovf[i] | (cnt[i] == CMAX);
                           end else begin
                               st_nx[i]    = DONE;
                               done_ent[i] = 1'b1;
                           end
                    default: st_nx[i] = st[i];
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < N_CH; i++) begin
                st[i]      <= IDLE;
                cnt[i]     <= '0;
                tot_lat[i] <= '0;
            end
            ovf     <= '0;
            ovf_lat <= '0;
            valid   <= '0;
            HIT     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                st[i]  <= st_nx[i];
                cnt[i] <= cnt_nx[i];
                if (done_ent[i]) begin
                    tot_lat[i] <= cnt[i];
                    ovf_lat[i] <= ovf[i];
                end
                valid[i] <= done_ent[i] | (valid[i] & ~cs_rise);
            end
            ovf <= ovf_nx;
            HIT <= hit_nx;
        end
    end

    always_comb begin
        snap = '0;
        for (int i = 0; i < N_CH; i++)
            snap[i*(CNT_W+2) +: CNT_W+2] = {valid[i], ovf_lat[i], tot_lat[i]};
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bcnt     <= '0;
            gpio_reg <= '0;
            ch_en    <= '1;
        end else begin
            if (cs_fall) begin
                tx_sr <= snap;
                bcnt  <= '0;
            end else if (!cs_d) begin
                if (sclk_fall)
                    tx_sr <= tx_sr << 1;
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[CFG_W-2:0], mosi_s};
                    bcnt  <= (bcnt == 8'hFF) ? bcnt : bcnt + 8'd1;
                end
            end
            if (cs_rise && bcnt >= 8'(CFG_W))
                {ch_en, gpio_reg} <= rx_sr;
        end
    end

    assign MISO    = ~CS_B & ~cs_d & tx_sr[SNAP_W-1];
    assign INJ_OUT = INJ_IN;
    assign GPIO    = gpio_reg;
    assign LED     = |HIT;
endmodule

// File: tb/tb_afe_tot_array.sv
// tb_afe_tot_array: directed and randomized checks of afe_tot_array against
// a pulse-length model of TOT results, hit flags and SPI configuration.
module tb_afe_tot_array;
    logic       CLK = 1'b0;
    logic       RST_B, INJ_IN, CS_B, SCLK, MOSI;
    logic [3:0] COMP;
    logic       MISO, INJ_OUT, LED;
    logic [3:0] HIT;
    logic [7:0] GPIO;

    int n_cmp = 0;
    int n_err = 0;

    int         m_tot [4];
    bit         m_ovf [4];
    bit         m_valid [4];
    bit         m_armed [4];
    logic [3:0] m_hit, m_en;
    logic [7:0] m_gpio;
    logic [11:0] m_rx;
    int         m_bits;

    afe_tot_array #(.N_CH(4), .CNT_W(8), .GPIO_W(8)) dut (
        .CLK(CLK), .RST_B(RST_B), .INJ_IN(INJ_IN), .COMP(COMP), .CS_B(CS_B),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .HIT(HIT), .INJ_OUT(INJ_OUT),
        .GPIO(GPIO), .LED(LED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] exp_snap();
        logic [39:0] s = '0;
        for (int i = 0; i < 4; i++)
            s |= 40'({m_valid[i], m_ovf[i], 8'(m_tot[i])}) << (i * 10);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tot[i] = 0; m_ovf[i] = 0; m_valid[i] = 0; m_armed[i] = 0;
        end
        m_hit = '0; m_en = '1; m_gpio = '0; m_rx = '0; m_bits = 0;
    endtask

    task automatic arm();
        INJ_IN = 1'b0;
        tick(3);
        INJ_IN = 1'b1;
        tick(4);
        m_hit = '0;
        for (int i = 0; i < 4; i++) m_armed[i] = m_en[i];
    endtask

    task automatic pulse(input int ch, input int len);
        COMP[ch] = 1'b1;
        tick(len);
        COMP[ch] = 1'b0;
        tick(4);
        if (m_armed[ch]) begin
            m_armed[ch] = 0;
            m_hit[ch]   = 1'b1;
            m_valid[ch] = 1;
            m_tot[ch]   = (len > 255) ? 255 : len;
            m_ovf[ch]   = (len > 255);
        end
    endtask

    task automatic cs_begin();
        CS_B = 1'b0;
        m_bits = 0;
        tick(4);
    endtask

    task automatic spi_bit(input logic b, output logic o);
        MOSI = b;
        tick(4);
        o = MISO;
        SCLK = 1'b1;
        tick(4);
        SCLK = 1'b0;
        m_rx = {m_rx[10:0], b};
        m_bits++;
    endtask

    task automatic cs_end();
        tick(4);
        CS_B = 1'b1;
        tick(6);
        if (m_bits >= 12) {m_en, m_gpio} = m_rx;
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
    endtask

    task automatic frame(input int n, input logic [63:0] tx, output logic [63:0] rx);
        logic o;
        rx = '0;
        cs_begin();
        for (int k = 0; k < n; k++) begin
            spi_bit(tx[n-1-k], o);
            rx = {rx[62:0], o};
        end
        cs_end();
    endtask

    task automatic do_read(input string tag, input logic [7:0] gv);
        logic [63:0] rx;
        logic [39:0] es;
        es = exp_snap();
        frame(48, 64'({m_en, gv}), rx);
        chk({tag, "_snap"}, 64'(rx[47:8]), 64'(es));
        chk({tag, "_tail"}, 64'(rx[7:0]), 64'(0));
        chk({tag, "_gpio"}, 64'(GPIO), 64'(m_gpio));
    endtask

    initial begin
        logic [63:0] rx;
        logic        o;
        logic [3:0]  mask;
        RST_B = 1'b0; INJ_IN = 1'b0; COMP = '0; CS_B = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        model_reset();
        tick(3);
        chk("rst_hit", 64'(HIT), 64'(0));
        chk("rst_miso", 64'(MISO), 64'(0));
        chk("rst_gpio", 64'(GPIO), 64'(0));
        chk("rst_led", 64'(LED), 64'(0));
        chk("rst_injout", 64'(INJ_OUT), 64'(0));
        RST_B = 1'b1;
        tick(2);
        arm();
        chk("injout_hi", 64'(INJ_OUT), 64'(1));

        // hit latency on channel 0, then a 20-cycle pulse
        COMP[0] = 1'b1;
        tick(2);
        chk("hit_lat2", 64'(HIT), 64'(0));
        tick(1);
        chk("hit_lat3", 64'(HIT), 64'(1));
        tick(17);
        COMP[0] = 1'b0;
        tick(4);
        m_armed[0] = 0; m_hit[0] = 1'b1; m_valid[0] = 1; m_tot[0] = 20; m_ovf[0] = 0;
        chk("led_on", 64'(LED), 64'(1));
        do_read("read20", 8'($urandom_range(0, 255)));
        do_read("reread", 8'($urandom_range(0, 255)));

        // saturation and DONE-ignore on channel 2
        pulse(2, 300);
        pulse(2, 10);
        chk("hit_sat", 64'(HIT), 64'(m_hit));
        do_read("sat", 8'($urandom_range(0, 255)));

        // randomized arm / pulse / read rounds
        for (int r = 0; r < 6; r++) begin
            arm();
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++)
                if (mask[c]) pulse(c, $urandom_range(1, 400));
            chk("rnd_hit", 64'(HIT), 64'(m_hit));
            chk("rnd_led", 64'(LED), 64'(|m_hit));
            do_read("rnd", 8'($urandom_range(0, 255)));
        end

        // 12-bit config write disabling all channels
        frame(12, 64'h0A5, rx);
        chk("cfg_gpio", 64'(GPIO), 64'hA5);
        arm();
        pulse(1, 5);
        chk("dis_hit", 64'(HIT), 64'(0));
        chk("dis_led", 64'(LED), 64'(0));
        do_read("dis", 8'hA5);
        frame(10, 64'($urandom_range(0, 1023)), rx);
        chk("short_gpio", 64'(GPIO), 64'hA5);
        frame(12, 64'({4'hF, 8'($urandom_range(0, 255))}), rx);
        chk("reen_gpio", 64'(GPIO), 64'(m_gpio));

        // injection drop mid-count on channel 3
        arm();
        do_read("pre_abort", m_gpio);
        pulse(3, 9);
        do_read("pre_abort2", m_gpio);
        arm();
        COMP[3] = 1'b1;
        tick(10);
        chk("cnt_hit", 64'(HIT), 64'(8));
        INJ_IN = 1'b0;
        tick(2);
        INJ_IN = 1'b1;
        COMP[3] = 1'b0;
        tick(4);
        m_hit = '0;
        for (int i = 0; i < 4; i++) m_armed[i] = m_en[i];
        chk("abort_hit", 64'(HIT), 64'(0));
        do_read("abort", m_gpio);
        pulse(3, 7);
        do_read("rearm", m_gpio);

        // reset in the middle of a frame and of a count
        arm();
        COMP[1] = 1'b1;
        tick(10);
        cs_begin();
        for (int k = 0; k < 6; k++) spi_bit(1'b1, o);
        RST_B = 1'b0;
        tick(2);
        chk("mid_rst_miso", 64'(MISO), 64'(0));
        chk("mid_rst_gpio", 64'(GPIO), 64'(0));
        chk("mid_rst_led", 64'(LED), 64'(0));
        chk("mid_rst_hit", 64'(HIT), 64'(0));
        COMP[1] = 1'b0;
        model_reset();
        RST_B = 1'b1;
        tick(2);
        for (int k = 0; k < 8; k++) spi_bit(1'b1, o);
        cs_end();
        chk("post_rst_gpio", 64'(GPIO), 64'(0));
        do_read("post_rst", 8'h00);
        arm();
        for (int c = 0; c < 4; c++) pulse(c, 3);
        chk("post_rst_en", 64'(HIT), 64'hF);
        do_read("final", 8'($urandom_range(0, 255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
